beam_trigger_scaler: RTL and testbench
======================================

Name: beam_trigger_scaler

Overview:
- Downstream of the low-amplitude beamformer. Consumes its per-beam trigger bits: NBEAMS trigger-threshold bits plus NBEAMS servo-threshold bits.
- Counts the rising edges on each bit over a fixed gate period, then transfers all counts at once into a shadow bank.
- The shadow bank is readable via a one-cycle registered read port. Software uses these rates to servo the 18-bit beam thresholds.

Parameters:
- NBEAMS, 2, number of beams; input is 2*NBEAMS bits.
- CNT_BITS, 16, width of each scaler counter and of rd_data_o.
- PERIOD_CYCLES, 375000, gate length in clk_i cycles (1 ms at 375 MHz); must be >= 4.
- Localparam NSCAL = 2*NBEAMS.
- Localparam AW = $clog2(NSCAL+1).

Ports:
- clk_i, input, 1: sole clock (ACLK domain).
- rst_ni, input, 1: reset, synchronous, active-low.
- trig_i, input, NSCAL: bit b<NBEAMS is the trigger-threshold hit for beam b; bit NBEAMS+b is the servo-threshold hit for beam b.
- rd_en_i, input, 1: read strobe.
- rd_addr_i, input, AW: scaler index 0..NSCAL-1; NSCAL selects the status word.
- rd_data_o, output, CNT_BITS: read data.
- rd_valid_o, output, 1: rd_data_o valid.
- period_o, output, 1: one-cycle pulse when the shadow bank updates.

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - live counters, shadow bank, gate counter, sequence counter, rd_data_o, rd_valid_o and period_o all go to 0;
  - the previous-trigger register goes to all ones, so a bit held high through reset release is not counted.
- Edge detect:
  - edge[k] = trig_i[k] & ~prev[k], with prev <= trig_i every cycle;
  - a level held high counts once; a bit toggling every cycle counts one per two cycles.
- Live counters: each live counter adds edge[k] per cycle and saturates at 2^CNT_BITS-1 (no wrap).
- Gate counter: counts 0..PERIOD_CYCLES-1, then wraps.
- Terminal cycle (gate == PERIOD_CYCLES-1):
  - shadow[k] <= sat(live[k] + edge[k]), so an edge on the terminal cycle belongs to the closing period;
  - live[k] <= 0;
  - seq <= seq+1 (CNT_BITS wide, wraps);
  - period_o is high on the following cycle.
- Period boundary: an edge on the cycle after the terminal cycle (gate==0) lands in the new period.
- Reads:
  - rd_en_i sampled at cycle N gives rd_valid_o=1 and rd_data_o at cycle N+1;
  - rd_valid_o is 0 on cycles with no preceding rd_en_i;
  - rd_data_o holds its last value when there is no read.
- Read address decode:
  - addr < NSCAL returns shadow[addr];
  - addr == NSCAL returns seq;
  - addr > NSCAL returns 0.
- Read on the terminal cycle returns the pre-update shadow and seq. A read on the next cycle returns the new values.
- Back-to-back reads are supported every cycle.
- Reset mid-period: discards live and shadow counts. The gate restarts at 0, so the first post-reset transfer occurs PERIOD_CYCLES cycles after reset deasserts.
- No other handshake; the block never stalls.

Decomposition:
- Shared package (beam_trigger_pkg) holds:
  - NSCAL_PER_BEAM = 2;
  - scaler index enum: TRIG_BASE=0, SERVO_BASE=NBEAMS;
  - STATUS_ADDR = NSCAL.
- One sub-module, scaler_counter (single edge-detect + saturating counter + shadow register), instantiated NSCAL times.
- The gate counter, sequence counter and read mux live in the top level.

Test Plan:
- Reset with trig_i held all ones, release, hold for 1 period (PERIOD_CYCLES=16 in bench) -> all shadows read 0, seq reads 1, period_o pulses once at cycle 16 after release.
- Pulse trig_i[0] high for 1 cycle, 5 times, spaced 2 cycles apart; hold trig_i[3] high for 10 cycles -> shadow[0]=5, shadow[3]=1, others 0.
- CNT_BITS=4, toggle trig_i[1] every cycle for 64 cycles within a 100-cycle period -> shadow[1]=15 (saturated, not wrapped).
- Rising edge on gate==15, then another on gate==0 -> first transfer reports 1, next transfer reports 1.
- Read addr 1 on the terminal cycle -> old value; read addr 1 on the next cycle -> new value; read addr NSCAL+1 -> 0 with rd_valid_o=1.
- Assert rst_ni low at gate==8 with counts accumulated -> all reads return 0; the next period_o pulse occurs 16 cycles after rst_ni rises.

Source files
------------

// File: rtl/beam_trigger_pkg.sv
// Shared constants for the beam trigger rate scalers: scaler index layout and
// the status word address that follows the per-scaler shadow registers.
package beam_trigger_pkg;

    localparam int NBEAMS_DEF     = 2;
    localparam int NSCAL_PER_BEAM = 2;

    // Trigger-threshold bits occupy the low half of trig_i, servo bits the high half.
    typedef enum int unsigned {
        TRIG_BASE  = 0,
        SERVO_BASE = NBEAMS_DEF
    } scaler_base_e;

    localparam int STATUS_ADDR = NSCAL_PER_BEAM * NBEAMS_DEF;

endpackage

// File: rtl/beam_trigger_scaler_counter.sv
// One rate scaler: rising-edge detector, saturating live counter, and the
// shadow register that captures the closing count on the terminal gate cycle.
module scaler_counter #(
    parameter int CNT_BITS = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                trig_i,
    input  logic                terminal_i,
    output logic [CNT_BITS-1:0] shadow_o
);

    logic                prev_q;
    logic                hit;
    logic [CNT_BITS-1:0] live_q;
    logic [CNT_BITS-1:0] live_nxt;

    assign hit      = trig_i & ~prev_q;
    assign live_nxt = (hit && (live_q != '1)) ? live_q + CNT_BITS'(1) : live_q;

    // prev resets high so a level held across reset release is not an edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_q   <= 1'b1;
            live_q   <= '0;
            shadow_o <= '0;
        end else begin
            prev_q <= trig_i;
            if (terminal_i) begin
                shadow_o <= live_nxt;
                live_q   <= '0;
            end else begin
                live_q <= live_nxt;
            end
        end
    end

endmodule

// File: rtl/beam_trigger_scaler.sv
// Per-beam trigger rate scalers: gated edge counts transferred to a shadow bank
// once per period, exposed through a one-cycle registered read port.
module beam_trigger_scaler
    import beam_trigger_pkg::*;
#(
    parameter  int NBEAMS        = 2,
    parameter  int CNT_BITS      = 16,
    parameter  int PERIOD_CYCLES = 375000,
    localparam int NSCAL         = NSCAL_PER_BEAM * NBEAMS,
    localparam int AW            = $clog2(NSCAL + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NSCAL-1:0]    trig_i,
    input  logic                rd_en_i,
    input  logic [AW-1:0]       rd_addr_i,
    output logic [CNT_BITS-1:0] rd_data_o,
    output logic                rd_valid_o,
    output logic                period_o
);

    localparam int GW = $clog2(PERIOD_CYCLES);

    logic [GW-1:0]                  gate_q;
    logic                           terminal;
    logic [CNT_BITS-1:0]            seq_q;
    logic [NSCAL-1:0][CNT_BITS-1:0] shadow;
    logic [CNT_BITS-1:0]            rd_mux;

    assign terminal = (gate_q == GW'(PERIOD_CYCLES - 1));

    for (genvar k = 0; k < NSCAL; k++) begin : g_scal
        scaler_counter #(
            .CNT_BITS (CNT_BITS)
        ) u_scal (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .trig_i     (trig_i[k]),
            .terminal_i (terminal),
            .shadow_o   (shadow[k])
        );
    end

    // Addresses past the status word read as zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NSCAL; k++) begin
            if (rd_addr_i == AW'(k)) rd_mux = shadow[k];
        end
        if (rd_addr_i == AW'(NSCAL)) rd_mux = seq_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gate_q     <= '0;
            seq_q      <= '0;
            period_o   <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            period_o   <= terminal;
            rd_valid_o <= rd_en_i;
            if (terminal) begin
                gate_q <= '0;
                seq_q  <= seq_q + CNT_BITS'(1);
            end else begin
                gate_q <= gate_q + GW'(1);
            end
            if (rd_en_i) rd_data_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_beam_trigger_scaler.sv
// Directed bench for beam_trigger_scaler: a 16-cycle-gate instance for the main
// sequence and a 4-bit, 100-cycle instance for counter saturation.
module tb_beam_trigger_scaler;

    logic        clk = 1'b0;
    logic        rst_ni, rd_en, rd_valid, period;
    logic [3:0]  trig;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;

    logic        s_rst_n, s_rd_en, s_rd_valid, s_period;
    logic [3:0]  s_trig;
    logic [2:0]  s_rd_addr;
    logic [3:0]  s_rd_data;

    int checks = 0;
    int errors = 0;
    int gm     = 0;
    int gs     = 0;
    int exp_seq = 0;
    int last_rd = 0;

    always #5 clk = ~clk;

    beam_trigger_scaler #(.NBEAMS(2), .CNT_BITS(16), .PERIOD_CYCLES(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .trig_i(trig), .rd_en_i(rd_en),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid), .period_o(period)
    );

    beam_trigger_scaler #(.NBEAMS(2), .CNT_BITS(4), .PERIOD_CYCLES(100)) dut_sat (
        .clk_i(clk), .rst_ni(s_rst_n), .trig_i(s_trig), .rd_en_i(s_rd_en),
        .rd_addr_i(s_rd_addr), .rd_data_o(s_rd_data), .rd_valid_o(s_rd_valid), .period_o(s_period)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; gm/gs track each DUT's gate value after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_ni) begin
            gm = 0; exp_seq = 0;
        end else if (gm == 15) begin
            gm = 0; exp_seq = (exp_seq + 1) & 16'hffff;
        end else gm++;
        if (!s_rst_n) gs = 0;
        else gs = (gs == 99) ? 0 : gs + 1;
        #1;
    endtask

    task automatic wait_gate(input int g);
        for (int n = 0; n < 40 && gm != g; n++) tick();
    endtask

    task automatic wait_sgate(input int g);
        for (int n = 0; n < 220 && gs != g; n++) tick();
    endtask

    task automatic rd(input int a, input int e);
        rd_en = 1'b1;
        rd_addr = 3'(a);
        tick();
        check($sformatf("rd_valid a%0d", a), 32'(rd_valid), 32'd1);
        check($sformatf("rd_data a%0d", a), 32'(rd_data), 32'(e));
        last_rd = e;
    endtask

    task automatic rd_idle();
        rd_en = 1'b0;
        tick();
        check("rd_valid idle", 32'(rd_valid), 32'd0);
        check("rd_data hold", 32'(rd_data), 32'(last_rd));
    endtask

    task automatic srd(input int a, input int e);
        s_rd_en = 1'b1;
        s_rd_addr = 3'(a);
        tick();
        check($sformatf("sat rd_valid a%0d", a), 32'(s_rd_valid), 32'd1);
        check($sformatf("sat rd_data a%0d", a), 32'(s_rd_data), 32'(e));
        s_rd_en = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; s_rst_n = 1'b0;
        trig = 4'hf; s_trig = 4'h0;
        rd_en = 1'b0; rd_addr = '0; s_rd_en = 1'b0; s_rd_addr = '0;
        repeat (3) tick();
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        check("reset period", 32'(period), 32'd0);
        check("sat reset rd_data", 32'(s_rd_data), 32'd0);

        // Held-high trigger through release: no counts, period_o on 16th edge.
        rst_ni = 1'b1; s_rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("period c%0d", i), 32'(period), 32'(i == 16));
        end
        for (int a = 0; a < 4; a++) rd(a, 0);
        rd(4, exp_seq);
        rd_idle();
        trig = 4'h0;

        // Five single-cycle pulses on bit 0, one 10-cycle level on bit 3.
        wait_gate(0);
        for (int i = 0; i < 16; i++) begin
            trig[0] = (i % 3 == 0) && (i < 15);
            trig[3] = (i < 10);
            tick();
        end
        trig = 4'h0;
        rd(0, 5); rd(1, 0); rd(2, 0); rd(3, 1);
        rd(4, exp_seq);
        rd_idle();

        // Edge sampled on the terminal cycle vs. on gate 0.
        wait_gate(15);
        trig = 4'b0100;
        tick();
        trig = 4'b0110;
        rd(2, 1);
        rd(1, 0);
        trig = 4'h0;
        rd_en = 1'b0;
        wait_gate(0);
        rd(1, 1);
        rd(2, 0);
        rd_en = 1'b0;

        // Terminal-cycle read returns old shadow, next cycle the new one.
        for (int i = 0; i < 3; i++) begin
            trig = 4'b0010; tick();
            trig = 4'h0;    tick();
        end
        wait_gate(15);
        rd(1, 1);
        rd(1, 3);
        rd(5, 0);
        rd(4, exp_seq);
        rd_idle();

        // Reset mid-period with live counts pending.
        for (int i = 0; i < 2; i++) begin
            trig = 4'b1000; tick();
            trig = 4'h0;    tick();
        end
        wait_gate(8);
        rst_ni = 1'b0;
        trig = 4'b0001;
        tick(); tick();
        check("mid reset rd_data", 32'(rd_data), 32'd0);
        check("mid reset period", 32'(period), 32'd0);
        rst_ni = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            rd_en = (i <= 5);
            rd_addr = 3'(i - 1);
            tick();
            check($sformatf("post-reset period c%0d", i), 32'(period), 32'(i == 16));
            if (i <= 5) begin
                check($sformatf("post-reset rd_valid a%0d", i - 1), 32'(rd_valid), 32'd1);
                check($sformatf("post-reset rd_data a%0d", i - 1), 32'(rd_data), 32'd0);
            end
        end
        rd(0, 0);
        rd(4, exp_seq);
        rd_en = 1'b0;
        trig = 4'h0;

        // 32 edges into a 4-bit counter must stick at 15.
        wait_sgate(0);
        for (int i = 0; i < 64; i++) begin
            s_trig[1] = ~s_trig[1];
            tick();
        end
        s_trig = 4'h0;
        wait_sgate(0);
        srd(1, 15);
        srd(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
